// File: rtl/complex_cal_sched.sv
// complex_cal_sched: round-robin sharing of one complex_cal core by two
// requesters, with in-order tag steering of results and error monitoring.
module complex_cal_sched #(
    parameter int D_WIDTH = 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req_vld,
    output logic               a_req_rdy,
    input  logic               a_mode,
    input  logic [D_WIDTH-1:0] a_re_1,
    input  logic [D_WIDTH-1:0] a_im_1,
    input  logic [D_WIDTH-1:0] a_re_2,
    input  logic [D_WIDTH-1:0] a_im_2,
    input  logic               b_req_vld,
    output logic               b_req_rdy,
    input  logic               b_mode,
    input  logic [D_WIDTH-1:0] b_re_1,
    input  logic [D_WIDTH-1:0] b_im_1,
    input  logic [D_WIDTH-1:0] b_re_2,
    input  logic [D_WIDTH-1:0] b_im_2,
    output logic               a_rsp_vld,
    output logic               b_rsp_vld,
    output logic [D_WIDTH-1:0] rsp_re,
    output logic [D_WIDTH-1:0] rsp_im,
    output logic               cc_din_vld,
    output logic               cc_cal_mode,
    output logic [D_WIDTH-1:0] cc_din_re_1,
    output logic [D_WIDTH-1:0] cc_din_im_1,
    output logic [D_WIDTH-1:0] cc_din_re_2,
    output logic [D_WIDTH-1:0] cc_din_im_2,
    input  logic [D_WIDTH-1:0] cc_dout_re,
    input  logic [D_WIDTH-1:0] cc_dout_im,
    input  logic               cc_dout_vld,
    output logic               busy,
    input  logic               err_clr,
    output logic               err_unexp,
    output logic               err_timeout
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);

    logic               r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_wp;
    logic [PW-1:0]      r_rp;
    logic [MAX_OUT-1:0] r_tag;
    logic [WW-1:0]      r_wd;

    logic w_elig;
    logic w_hs_a;
    logic w_hs_b;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_unexp;
    logic w_wd_hit;

    // r_ptr = 0 favours A, 1 favours B on a tie
    always_comb begin
        w_empty   = (r_cnt == '0);
        w_elig    = !rst && (r_cnt < CW'(MAX_OUT));
        a_req_rdy = w_elig && a_req_vld && (!b_req_vld || !r_ptr);
        b_req_rdy = w_elig && b_req_vld && (!a_req_vld || r_ptr);
        w_hs_a    = a_req_vld && a_req_rdy;
        w_hs_b    = b_req_vld && b_req_rdy;
        w_push    = w_hs_a || w_hs_b;
        w_pop     = cc_dout_vld && !w_empty;
        w_unexp   = cc_dout_vld && w_empty;
        w_wd_hit  = (r_wd == WW'(TIMEOUT - 1));
        busy      = !w_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_tag <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wp] <= w_hs_b;
                r_wp        <= r_wp + PW'(1);
                r_ptr       <= w_hs_a;
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_din_vld  <= 1'b0;
            cc_cal_mode <= 1'b0;
            cc_din_re_1 <= '0;
            cc_din_im_1 <= '0;
            cc_din_re_2 <= '0;
            cc_din_im_2 <= '0;
        end else begin
            cc_din_vld <= w_push;
            if (w_hs_a) begin
                cc_cal_mode <= a_mode;
                cc_din_re_1 <= a_re_1;
                cc_din_im_1 <= a_im_1;
                cc_din_re_2 <= a_re_2;
                cc_din_im_2 <= a_im_2;
            end else if (w_hs_b) begin
                cc_cal_mode <= b_mode;
                cc_din_re_1 <= b_re_1;
                cc_din_im_1 <= b_im_1;
                cc_din_re_2 <= b_re_2;
                cc_din_im_2 <= b_im_2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rsp_vld <= 1'b0;
            b_rsp_vld <= 1'b0;
            rsp_re    <= '0;
            rsp_im    <= '0;
        end else begin
            a_rsp_vld <= w_pop && !r_tag[r_rp];
            b_rsp_vld <= w_pop && r_tag[r_rp];
            if (w_pop) begin
                rsp_re <= cc_dout_re;
                rsp_im <= cc_dout_im;
            end
        end
    end

    // A new error event takes priority over a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd        <= '0;
            err_unexp   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (w_empty || cc_dout_vld) begin
                r_wd <= '0;
            end else if (!w_wd_hit) begin
                r_wd <= r_wd + WW'(1);
            end
            if (w_unexp) begin
                err_unexp <= 1'b1;
            end else if (err_clr) begin
                err_unexp <= 1'b0;
            end
            if (w_wd_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_complex_cal_sched.sv
// tb_complex_cal_sched: table-driven arbitration vectors, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_complex_cal_sched;
    localparam int DW = 8;
    localparam int MO = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_vld = 1'b0, b_req_vld = 1'b0;
    logic          a_req_rdy, b_req_rdy;
    logic          a_mode = 1'b0, b_mode = 1'b0;
    logic [DW-1:0] a_re_1 = '0, a_im_1 = '0, a_re_2 = '0, a_im_2 = '0;
    logic [DW-1:0] b_re_1 = '0, b_im_1 = '0, b_re_2 = '0, b_im_2 = '0;
    logic          a_rsp_vld, b_rsp_vld;
    logic [DW-1:0] rsp_re, rsp_im;
    logic          cc_din_vld, cc_cal_mode;
    logic [DW-1:0] cc_din_re_1, cc_din_im_1, cc_din_re_2, cc_din_im_2;
    logic [DW-1:0] cc_dout_re = '0, cc_dout_im = '0;
    logic          cc_dout_vld = 1'b0;
    logic          busy;
    logic          err_clr = 1'b0;
    logic          err_unexp, err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    complex_cal_sched #(.D_WIDTH(DW), .MAX_OUT(MO), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .a_req_vld(a_req_vld), .a_req_rdy(a_req_rdy), .a_mode(a_mode),
        .a_re_1(a_re_1), .a_im_1(a_im_1), .a_re_2(a_re_2), .a_im_2(a_im_2),
        .b_req_vld(b_req_vld), .b_req_rdy(b_req_rdy), .b_mode(b_mode),
        .b_re_1(b_re_1), .b_im_1(b_im_1), .b_re_2(b_re_2), .b_im_2(b_im_2),
        .a_rsp_vld(a_rsp_vld), .b_rsp_vld(b_rsp_vld),
        .rsp_re(rsp_re), .rsp_im(rsp_im),
        .cc_din_vld(cc_din_vld), .cc_cal_mode(cc_cal_mode),
        .cc_din_re_1(cc_din_re_1), .cc_din_im_1(cc_din_im_1),
        .cc_din_re_2(cc_din_re_2), .cc_din_im_2(cc_din_im_2),
        .cc_dout_re(cc_dout_re), .cc_dout_im(cc_dout_im),
        .cc_dout_vld(cc_dout_vld), .busy(busy), .err_clr(err_clr),
        .err_unexp(err_unexp), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       bv;
        logic       dv;
        logic       ea;
        logic       eb;
        logic       ebusy;
        logic [1:0] ersp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [56:0] all_outs();
        return {a_req_rdy, b_req_rdy, a_rsp_vld, b_rsp_vld, rsp_re, rsp_im,
                cc_din_vld, cc_cal_mode, cc_din_re_1, cc_din_im_1,
                cc_din_re_2, cc_din_im_2, busy, err_unexp, err_timeout};
    endfunction

    // Stand-in for the complex_cal core: mode 1 adds, mode 0 multiplies
    function automatic logic [15:0] cal(input logic m,
                                        input logic [7:0] r1, i1, r2, i2);
        logic [7:0] re, im;
        if (m) begin
            re = r1 + r2;
            im = i1 + i2;
        end else begin
            re = r1 * r2 - i1 * i2;
            im = r1 * i2 + i1 * r2;
        end
        return {re, im};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_req_vld = 1'b0;
        b_req_vld = 1'b0;
        cc_dout_vld = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic directed_a_only();
        do_reset();
        chk("reset_outs", 64'(all_outs()), 64'd0);
        a_req_vld = 1'b1;
        a_mode = 1'b0;
        a_re_1 = 8'h01; a_im_1 = 8'h02; a_re_2 = 8'h03; a_im_2 = 8'h04;
        #1;
        chk("d_a_rdy", a_req_rdy, 1);
        chk("d_b_rdy", b_req_rdy, 0);
        @(posedge clk); #1;
        a_req_vld = 1'b0;
        chk("d_iss", cc_din_vld, 1);
        chk("d_ops", {cc_cal_mode, cc_din_re_1, cc_din_im_1, cc_din_re_2,
                      cc_din_im_2}, {1'b0, 32'h01020304});
        chk("d_busy", busy, 1);
        @(posedge clk); #1;
        chk("d_iss_1cyc", cc_din_vld, 0);
        chk("d_ops_hold", cc_din_re_1, 8'h01);
        cc_dout_vld = 1'b1;
        cc_dout_re = 8'h11;
        cc_dout_im = 8'h22;
        #1;
        chk("d_no_early_rsp", a_rsp_vld, 0);
        @(posedge clk); #1;
        cc_dout_vld = 1'b0;
        chk("d_arsp", a_rsp_vld, 1);
        chk("d_brsp", b_rsp_vld, 0);
        chk("d_data", {rsp_re, rsp_im}, 16'h1122);
        chk("d_busy0", busy, 0);
        @(posedge clk); #1;
        chk("d_arsp_pulse", a_rsp_vld, 0);
    endtask

    task automatic table_run();
        do_reset();
        a_mode = 1'b1;
        a_re_1 = 8'h11; a_im_1 = 8'h12; a_re_2 = 8'h13; a_im_2 = 8'h14;
        b_mode = 1'b0;
        b_re_1 = 8'h21; b_im_1 = 8'h22; b_re_2 = 8'h23; b_im_2 = 8'h24;
        for (int i = 0; i < 12; i++) begin
            a_req_vld = tbl[i].av;
            b_req_vld = tbl[i].bv;
            cc_dout_vld = tbl[i].dv;
            cc_dout_re = 8'(8'h40 + i);
            cc_dout_im = 8'(8'h80 + i);
            #1;
            chk($sformatf("t%0d_ardy", i), a_req_rdy, tbl[i].ea);
            chk($sformatf("t%0d_brdy", i), b_req_rdy, tbl[i].eb);
            @(posedge clk); #1;
            chk($sformatf("t%0d_busy", i), busy, tbl[i].ebusy);
            chk($sformatf("t%0d_arsp", i), a_rsp_vld, tbl[i].ersp == 2'd1);
            chk($sformatf("t%0d_brsp", i), b_rsp_vld, tbl[i].ersp == 2'd2);
            chk($sformatf("t%0d_iss", i), cc_din_vld, tbl[i].ea | tbl[i].eb);
            if (tbl[i].ersp != 2'd0)
                chk($sformatf("t%0d_data", i), {rsp_re, rsp_im},
                    {8'(8'h40 + i), 8'(8'h80 + i)});
            if (tbl[i].ea)
                chk($sformatf("t%0d_opa", i), {cc_cal_mode, cc_din_re_1},
                    {1'b1, 8'h11});
            if (tbl[i].eb)
                chk($sformatf("t%0d_opb", i), {cc_cal_mode, cc_din_re_1},
                    {1'b0, 8'h21});
        end
        a_req_vld = 1'b0;
        b_req_vld = 1'b0;
        cc_dout_vld = 1'b0;
    endtask

    task automatic unexp_seq();
        do_reset();
        cc_dout_vld = 1'b1;
        @(posedge clk); #1;
        cc_dout_vld = 1'b0;
        chk("u_set", err_unexp, 1);
        chk("u_no_rsp", {a_rsp_vld, b_rsp_vld}, 2'b00);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("u_clr", err_unexp, 0);
        err_clr = 1'b1;
        cc_dout_vld = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        cc_dout_vld = 1'b0;
        chk("u_set_wins", err_unexp, 1);
    endtask

    task automatic timeout_seq();
        do_reset();
        b_req_vld = 1'b1;
        b_mode = 1'b1;
        b_re_1 = 8'h05; b_im_1 = 8'h06; b_re_2 = 8'h07; b_im_2 = 8'h08;
        #1;
        chk("w_brdy", b_req_rdy, 1);
        @(posedge clk); #1;
        b_req_vld = 1'b0;
        for (int k = 1; k < TO; k++) begin
            @(posedge clk); #1;
        end
        chk("w_not_yet", err_timeout, 0);
        @(posedge clk); #1;
        chk("w_expired", err_timeout, 1);
        chk("w_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("w_rst_outs", 64'(all_outs()), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        cc_dout_vld = 1'b1;
        cc_dout_re = 8'h5a;
        @(posedge clk); #1;
        cc_dout_vld = 1'b0;
        chk("w_late_unexp", err_unexp, 1);
        chk("w_late_no_rsp", {a_rsp_vld, b_rsp_vld}, 2'b00);
    endtask

    task automatic random_run(input int ncyc);
        int          tagq[$];
        logic [15:0] resa[$], resb[$], ccq[$];
        logic [15:0] d, exp_data;
        logic [32:0] exp_ops;
        bit          a_pend, b_pend, exp_iss, ea, eb, dv, elig;
        int          last_gnt, exp_rsp, t;
        do_reset();
        a_pend = 0; b_pend = 0; exp_iss = 0; exp_rsp = 0;
        last_gnt = -1; exp_ops = '0; exp_data = '0;
        for (int c = 0; c < ncyc; c++) begin
            chk("r_iss", cc_din_vld, exp_iss);
            if (exp_iss)
                chk("r_ops", {cc_cal_mode, cc_din_re_1, cc_din_im_1,
                              cc_din_re_2, cc_din_im_2}, exp_ops);
            chk("r_arsp", a_rsp_vld, exp_rsp == 1);
            chk("r_brsp", b_rsp_vld, exp_rsp == 2);
            if (exp_rsp != 0)
                chk("r_data", {rsp_re, rsp_im}, exp_data);
            chk("r_busy", busy, tagq.size() != 0);
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1;
                a_mode = 1'($urandom);
                a_re_1 = 8'($urandom); a_im_1 = 8'($urandom);
                a_re_2 = 8'($urandom); a_im_2 = 8'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1;
                b_mode = 1'($urandom);
                b_re_1 = 8'($urandom); b_im_1 = 8'($urandom);
                b_re_2 = 8'($urandom); b_im_2 = 8'($urandom);
            end
            a_req_vld = a_pend;
            b_req_vld = b_pend;
            dv = ccq.size() != 0 &&
                 $urandom_range(0, 7) < (((c / 50) % 2) ? 1 : 6);
            d = dv ? ccq[0] : 16'h0;
            cc_dout_vld = dv;
            {cc_dout_re, cc_dout_im} = d;
            if (cc_din_vld)
                ccq.push_back(cal(cc_cal_mode, cc_din_re_1, cc_din_im_1,
                                  cc_din_re_2, cc_din_im_2));
            #1;
            elig = tagq.size() < MO;
            ea = elig && a_pend && (!b_pend || last_gnt != 0);
            eb = elig && b_pend && (!a_pend || last_gnt == 0);
            chk("r_ardy", a_req_rdy, ea);
            chk("r_brdy", b_req_rdy, eb);
            exp_rsp = 0;
            if (dv) begin
                void'(ccq.pop_front());
                if (tagq.size() > 0) begin
                    t = tagq.pop_front();
                    exp_rsp = t + 1;
                    exp_data = (t == 1) ? resb.pop_front() : resa.pop_front();
                end
            end
            exp_iss = ea || eb;
            if (ea) begin
                exp_ops = {a_mode, a_re_1, a_im_1, a_re_2, a_im_2};
                tagq.push_back(0);
                resa.push_back(cal(a_mode, a_re_1, a_im_1, a_re_2, a_im_2));
                last_gnt = 0;
                a_pend = 0;
            end
            if (eb) begin
                exp_ops = {b_mode, b_re_1, b_im_1, b_re_2, b_im_2};
                tagq.push_back(1);
                resb.push_back(cal(b_mode, b_re_1, b_im_1, b_re_2, b_im_2));
                last_gnt = 1;
                b_pend = 0;
            end
            @(posedge clk); #1;
        end
        a_req_vld = 1'b0;
        b_req_vld = 1'b0;
        cc_dout_vld = 1'b0;
        chk("r_no_unexp", err_unexp, 0);
    endtask

    initial begin
        //          av    bv    dv    ea    eb    busy  rsp
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};

        directed_a_only();
        table_run();
        unexp_seq();
        timeout_seq();
        random_run(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/complex_cal_sched.md
Name: complex_cal_sched

Overview:
Two-requester scheduler that shares a single complex_cal datapath instance between requester A and requester B. Requests are arbitrated round-robin. Each winning request is issued to complex_cal as a one-cycle din_vld pulse. complex_cal returns results in order, so the block keeps an in-order tag FIFO of requester IDs and steers each result back to the requester that issued it. It sits between two upstream processing blocks and the complex_cal core, and adds outstanding-transaction limiting plus error/timeout monitoring.

Parameters:
D_WIDTH, 8, width of each real/imag operand and result component
MAX_OUT, 4, max in-flight operations (tag FIFO depth), power of 2, >=2
TIMEOUT, 64, cycles with work in flight and no cc_dout_vld before err_timeout is set

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
a_req_vld  in  1  requester A request valid
a_req_rdy  out  1  requester A accepted (handshake = vld & rdy)
a_mode  in  1  cal_mode for A's request
a_re_1, a_im_1, a_re_2, a_im_2  in  D_WIDTH each  A operands
b_req_vld, b_req_rdy, b_mode, b_re_1, b_im_1, b_re_2, b_im_2  same as A, for requester B
a_rsp_vld  out  1  one-cycle pulse, result for A valid
b_rsp_vld  out  1  one-cycle pulse, result for B valid
rsp_re, rsp_im  out  D_WIDTH each  result data, shared by both requesters, qualified by a_rsp_vld/b_rsp_vld
cc_din_vld  out  1  issue pulse to complex_cal
cc_cal_mode  out  1  to complex_cal
cc_din_re_1, cc_din_im_1, cc_din_re_2, cc_din_im_2  out  D_WIDTH each  to complex_cal
cc_dout_re, cc_dout_im  in  D_WIDTH each  from complex_cal
cc_dout_vld  in  1  from complex_cal
busy  out  1  outstanding count != 0
err_clr  in  1  clears sticky error flags
err_unexp  out  1  sticky: cc_dout_vld arrived with the tag FIFO empty
err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset values: all outputs 0. Tag FIFO empty. RR pointer favours A. Watchdog counter 0. Asserting rst mid-operation discards all in-flight tags; complex_cal results arriving afterwards set err_unexp.
- Eligibility: the block may grant only when outstanding count < MAX_OUT. Count = tag FIFO occupancy. A same-cycle pop does not free a slot for a same-cycle grant.
- Arbitration (combinational): exactly one rdy is high when eligible and at least one vld is high.
  - Only one vld high: that requester is granted.
  - Both vld high: the requester not granted most recently wins.
  - The pointer updates only on a completed handshake.
- Requesters must hold vld and operands stable until rdy. rdy never asserts without vld.
- Issue: on a handshake, register mode and operands. cc_din_vld = 1 for exactly one cycle in the following cycle (latency 1), with cc_* holding the registered values. cc_* hold their values otherwise. Back-to-back handshakes produce back-to-back cc_din_vld pulses.
- Tag FIFO: push the requester ID (0=A, 1=B) on handshake. Pop on cc_dout_vld. Simultaneous push and pop leaves the count unchanged. Read/write pointers are log2(MAX_OUT) bits and wrap naturally.
- Response: cc_dout_vld with FIFO non-empty registers cc_dout_re/im into rsp_re/im. The cycle after, pulse a_rsp_vld or b_rsp_vld according to the popped tag (latency 1). Never both.
- cc_dout_vld with FIFO empty: no pop, no rsp pulse, err_unexp <= 1.
- Watchdog: counter clears when count == 0 or on cc_dout_vld, otherwise increments. When it reaches TIMEOUT-1, err_timeout <= 1 and the counter saturates. Operation is not flushed.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the set wins.
- complex_cal latency is not assumed; results only need to be in order. At most MAX_OUT operations are in flight.

Test Plan:
- A only, mode 0, operands (1+2j),(3+4j) -> a_req_rdy same cycle, cc_din_vld one cycle later with 01,02,03,04; when complex_cal answers, a_rsp_vld pulses 1 cycle after cc_dout_vld, b_rsp_vld stays 0.
- A and B held valid continuously for 8 grants -> grants alternate A,B,A,B..., A first after reset; response tags alternate A,B matching issue order; rsp data matches the golden file per requester.
- complex_cal stalled (cc_dout_vld forced 0), 6 requests offered with MAX_OUT=4 -> exactly 4 handshakes, rdy low afterwards, busy=1. Release one result -> one more grant, issued no earlier than the next cycle.
- Same-cycle handshake and cc_dout_vld at count=3 -> count stays 3, both the issue pulse and the response pulse occur.
- cc_dout_vld injected with FIFO empty -> err_unexp=1, no rsp pulse. Pulse err_clr -> err_unexp=0.
- One request issued, no cc_dout_vld for TIMEOUT cycles -> err_timeout=1 at cycle TIMEOUT. Assert rst mid-flight -> all outputs 0, busy=0, and a late cc_dout_vld sets err_unexp.
